alu_req_arbiter: RTL and testbench
==================================

# alu_req_arbiter

Two-requester round-robin arbiter and transaction sequencer placed in front of the ALU command driver. Each requester submits one operation as {A, B, op} on a valid/ready port. The block grants one requester at a time and keeps exactly one ALU transaction outstanding. It routes the ALU response back to the granted requester and replaces a lost response with an error response after a programmable timeout.

## Interface
Parameters:
- DATA_W, 32, operand and result width
- TIMEOUT, 1024, number of WAIT cycles allowed for a response (legal range 2..65535)

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid / req1_valid  input  1  request present
- req0_ready / req1_ready  output  1  request accepted this cycle
- req0_a / req1_a  input  DATA_W  operand A
- req0_b / req1_b  input  DATA_W  operand B
- req0_op / req1_op  input  3  opcode; forwarded unchanged (AND 000, OR 001, ADD 100, SUB 101, all others reach the ALU as illegal)
- rsp0_valid / rsp1_valid  output  1  one-cycle response pulse
- rsp0_result / rsp1_result  output  DATA_W  result
- rsp0_flags / rsp1_flags  output  4  ALU flags {carry, overflow, zero, negative}
- rsp0_err / rsp1_err  output  1  ALU-reported error or timeout
- alu_cmd_valid  output  1  command to ALU driver
- alu_cmd_ready  input  1  driver accepts command
- alu_cmd_a, alu_cmd_b  output  DATA_W  operands
- alu_cmd_op  output  3  opcode
- alu_rsp_valid  input  1  one-cycle response from driver
- alu_rsp_result  input  DATA_W
- alu_rsp_flags  input  4
- alu_rsp_err  input  1
- busy  output  1  state != IDLE
- grant  output  1  index of current or most recent granted requester
- timeout  output  1  one-cycle pulse when a timeout response is generated

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Select a winner among the asserted reqN_valid inputs.
  - If only one requester is valid, it wins.
  - If both are valid, the requester other than last_grant wins.
  - The winner's reqN_ready is driven combinationally high in the same cycle.
  - On valid&ready: capture a, b, op; set grant and last_grant to the winner; go to ISSUE.
- ISSUE:
  - alu_cmd_valid=1 with the captured fields held stable.
  - On alu_cmd_ready=1: clear wait_cnt, go to WAIT.
  - No timeout applies in ISSUE; downstream backpressure may stall indefinitely.
- WAIT:
  - wait_cnt increments every cycle.
  - If alu_rsp_valid=1: register result, flags and err; go to RESP.
  - Else if wait_cnt==TIMEOUT-1: register result=0, flags=0, err=1; pulse timeout next cycle; go to RESP.
  - When alu_rsp_valid and the timeout condition occur in the same cycle, the response wins and no timeout is reported.
- RESP:
  - rsp<grant>_valid=1 for exactly one cycle with the registered fields.
  - The other requester's rsp outputs stay 0.
  - Next state is IDLE.
- alu_rsp_valid outside WAIT is ignored, with no state change and no response.
- reqN_ready is 0 in every state except IDLE.
- rspN_result, rspN_flags and rspN_err are 0 whenever rspN_valid=0.
- Fairness: with both requesters continuously valid, grants strictly alternate.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins first contention), grant=0.
  - wait_cnt=0, captured fields=0.
  - All outputs 0: ready, rsp*, alu_cmd_*, busy, timeout.
- Reset asserted in any state aborts the transaction: no response is produced and all outputs are 0 on the following cycle.
- Latency, with accept in cycle 0:
  - alu_cmd_valid in cycle 1.
  - alu_cmd_ready in cycle 1 gives WAIT from cycle 2.
  - alu_rsp_valid in cycle k≥2 gives rsp valid in cycle k+1.
  - The next request can be accepted in cycle k+2.
- Timeout: with the command accepted in cycle c, WAIT runs cycles c+1..c+TIMEOUT.
  - A response in cycle c+TIMEOUT is still accepted.
  - With no response, rspN_valid (err=1) and timeout both rise in cycle c+TIMEOUT+1.
- A requester may drop valid while not accepted; no request is latched unless ready was high.

## Test plan
- Single request: req0 {A=32'h0000_0005, B=32'h0000_0003, op=100}, driver ready immediately and replies 32'h8, flags 0, 2 cycles later -> alu_cmd_* in cycle 1, rsp0_valid pulse in cycle 4 with 32'h8, rsp1_valid stays 0, grant=0.
- Contention: req0 and req1 both held valid for 4 transactions -> grants 0,1,0,1, and each rspN returns to the matching requester.
- Backpressure: alu_cmd_ready low for 50 cycles -> alu_cmd_valid held with stable fields, no timeout, busy=1 throughout, transaction completes normally.
- Timeout: TIMEOUT=8, no alu_rsp_valid -> 8 WAIT cycles, then rspN_valid with result 0, flags 0, err=1 and timeout=1 in the same cycle.
- Boundary: with TIMEOUT=8, a response in the 8th WAIT cycle is delivered with err=alu_rsp_err and timeout=0; a stray alu_rsp_valid in IDLE produces no rsp.
- Reset mid-WAIT: rst for 1 cycle -> no response, outputs 0; the next contended request is granted to requester 0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: two-requester round-robin arbiter in front of the ALU
// command driver. Keeps exactly one ALU transaction in flight, routes the
// response back to the granted requester and substitutes an error response
// when the ALU stays silent for TIMEOUT wait cycles.
module alu_req_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024  // legal range 2..65535
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [3:0]        rsp0_flags,
  output logic              rsp0_err,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_result,
  output logic [3:0]        rsp1_flags,
  output logic              rsp1_err,
  // ALU driver side
  output logic              alu_cmd_valid,
  input  logic              alu_cmd_ready,
  output logic [DATA_W-1:0] alu_cmd_a,
  output logic [DATA_W-1:0] alu_cmd_b,
  output logic [2:0]        alu_cmd_op,
  input  logic              alu_rsp_valid,
  input  logic [DATA_W-1:0] alu_rsp_result,
  input  logic [3:0]        alu_rsp_flags,
  input  logic              alu_rsp_err,
  // status
  output logic              busy,
  output logic              grant,
  output logic              timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // Last WAIT cycle index; the counter starts at 0 in the first WAIT cycle.
  localparam logic [15:0] LP_WAIT_LAST = 16'(TIMEOUT - 1);

  state_t            r_state;
  logic              r_last_grant;
  logic              r_grant;
  logic [15:0]       r_wait_cnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_result;
  logic [3:0]        r_flags;
  logic              r_err;
  logic              r_timed_out;

  logic              w_any;
  logic              w_winner;
  logic              w_accept;
  logic              w_resp;

  // Winner selection: a lone requester wins, contention goes to the one not
  // granted last time. Ready is held low while reset is asserted.
  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    w_any    = req0_valid | req1_valid;
    w_winner = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    w_accept = (r_state == S_IDLE) & w_any & ~rst;
  end

  assign req0_ready = w_accept & ~w_winner;
  assign req1_ready = w_accept &  w_winner;

  // Transaction sequencer: accept, issue, wait for response or timeout, respond.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_wait_cnt   <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_result     <= '0;
      r_flags      <= '0;
      r_err        <= 1'b0;
      r_timed_out  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a          <= w_winner ? req1_a  : req0_a;
            r_b          <= w_winner ? req1_b  : req0_b;
            r_op         <= w_winner ? req1_op : req0_op;
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // No timeout here: downstream backpressure may stall indefinitely.
          if (alu_cmd_ready) begin
            r_wait_cnt <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 16'd1;
          if (alu_rsp_valid) begin
            // A real response beats a coincident timeout.
            r_result    <= alu_rsp_result;
            r_flags     <= alu_rsp_flags;
            r_err       <= alu_rsp_err;
            r_timed_out <= 1'b0;
            r_state     <= S_RESP;
          end else if (r_wait_cnt == LP_WAIT_LAST) begin
            r_result    <= '0;
            r_flags     <= '0;
            r_err       <= 1'b1;
            r_timed_out <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_timed_out <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Response routing: only the granted side sees the pulse; idle fields are 0.
  assign w_resp      = (r_state == S_RESP);
  assign rsp0_valid  = w_resp & ~r_grant;
  assign rsp1_valid  = w_resp &  r_grant;
  assign rsp0_result = rsp0_valid ? r_result : '0;
  assign rsp0_flags  = rsp0_valid ? r_flags  : '0;
  assign rsp0_err    = rsp0_valid & r_err;
  assign rsp1_result = rsp1_valid ? r_result : '0;
  assign rsp1_flags  = rsp1_valid ? r_flags  : '0;
  assign rsp1_err    = rsp1_valid & r_err;
  assign timeout     = w_resp & r_timed_out;

  assign alu_cmd_valid = (r_state == S_ISSUE);
  assign alu_cmd_a     = r_a;
  assign alu_cmd_b     = r_b;
  assign alu_cmd_op    = r_op;

  assign busy  = (r_state != S_IDLE);
  assign grant = r_grant;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// transaction-level model of the arbiter.
module tb_alu_req_arbiter;

  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]    req0_op = '0, req1_op = '0;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_result, rsp1_result;
  logic [3:0]    rsp0_flags, rsp1_flags;
  logic          rsp0_err, rsp1_err;
  logic          alu_cmd_valid;
  logic          alu_cmd_ready = 1'b0;
  logic [DW-1:0] alu_cmd_a, alu_cmd_b;
  logic [2:0]    alu_cmd_op;
  logic          alu_rsp_valid = 1'b0;
  logic [DW-1:0] alu_rsp_result = '0;
  logic [3:0]    alu_rsp_flags = '0;
  logic          alu_rsp_err = 1'b0;
  logic          busy, grant, timeout;

  alu_req_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
    .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
    .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
    .alu_cmd_valid(alu_cmd_valid), .alu_cmd_ready(alu_cmd_ready),
    .alu_cmd_a(alu_cmd_a), .alu_cmd_b(alu_cmd_b), .alu_cmd_op(alu_cmd_op),
    .alu_rsp_valid(alu_rsp_valid), .alu_rsp_result(alu_rsp_result),
    .alu_rsp_flags(alu_rsp_flags), .alu_rsp_err(alu_rsp_err),
    .busy(busy), .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Transaction-level reference: one outstanding transaction record with
  // the cycle its command was handed off; the timeout is a deadline.
  // ---------------------------------------------------------------------
  bit          m_act = 0;      // a request has been accepted and not yet answered
  bit          m_handed = 0;   // command taken by the ALU driver
  bit          m_have = 0;     // response (real or synthetic) ready to deliver
  bit          m_to = 0;       // the response is a timeout substitute
  bit          m_owner = 0;
  bit          m_last = 1;
  logic [DW-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [2:0]  m_op = '0;
  logic [3:0]  m_flg = '0;
  bit          m_err = 0;
  int          m_hand_cyc = 0;
  int          cyc = 0;

  always @(negedge clk) begin : compare
    bit any, win, er0, er1, ev0, ev1;
    any = req0_valid | req1_valid;
    win = (req0_valid && req1_valid) ? !m_last : req1_valid;
    er0 = !rst && !m_act && any && !win;
    er1 = !rst && !m_act && any && win;
    ev0 = m_act && m_have && !m_owner;
    ev1 = m_act && m_have && m_owner;

    check("m_req0_ready", req0_ready, er0);
    check("m_req1_ready", req1_ready, er1);
    check("m_busy", busy, m_act);
    check("m_grant", grant, m_owner);
    check("m_cmd_valid", alu_cmd_valid, m_act && !m_handed);
    if (m_act && !m_handed) begin
      check("m_cmd_a", alu_cmd_a, m_a);
      check("m_cmd_b", alu_cmd_b, m_b);
      check("m_cmd_op", alu_cmd_op, m_op);
    end
    check("m_rsp0_valid", rsp0_valid, ev0);
    check("m_rsp0_result", rsp0_result, ev0 ? m_res : '0);
    check("m_rsp0_flags", rsp0_flags, ev0 ? m_flg : 4'h0);
    check("m_rsp0_err", rsp0_err, ev0 && m_err);
    check("m_rsp1_valid", rsp1_valid, ev1);
    check("m_rsp1_result", rsp1_result, ev1 ? m_res : '0);
    check("m_rsp1_flags", rsp1_flags, ev1 ? m_flg : 4'h0);
    check("m_rsp1_err", rsp1_err, ev1 && m_err);
    check("m_timeout", timeout, m_act && m_have && m_to);

    // Advance the model to the state after the coming rising edge.
    if (rst) begin
      m_act = 0; m_handed = 0; m_have = 0; m_to = 0;
      m_owner = 0; m_last = 1;
    end else if (!m_act) begin
      if (any) begin
        m_act = 1; m_handed = 0; m_have = 0; m_to = 0;
        m_owner = win; m_last = win;
        m_a  = win ? req1_a  : req0_a;
        m_b  = win ? req1_b  : req0_b;
        m_op = win ? req1_op : req0_op;
      end
    end else if (m_have) begin
      m_act = 0;
    end else if (!m_handed) begin
      if (alu_cmd_ready) begin
        m_handed = 1;
        m_hand_cyc = cyc;
      end
    end else if (alu_rsp_valid) begin
      m_have = 1; m_to = 0;
      m_res = alu_rsp_result; m_flg = alu_rsp_flags; m_err = alu_rsp_err;
    end else if (cyc == m_hand_cyc + TO) begin
      m_have = 1; m_to = 1;
      m_res = '0; m_flg = 4'h0; m_err = 1;
    end
    cyc++;
  end

  // One directed transaction with literal expectations. dly is the WAIT
  // cycle (1-based) carrying the ALU reply; dly < 0 means no reply.
  task automatic txn(input bit v0, input bit v1, input bit hold, input int bp,
                     input int dly, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic [2:0] op, input logic [DW-1:0] res,
                     input logic [3:0] flg, input logic e, input bit exp_g,
                     input string tag);
    logic [DW-1:0] ea, eb;
    bit to;
    to = (dly < 0);
    ea = exp_g ? ~a : a;
    eb = exp_g ? ~b : b;
    req0_valid = v0; req1_valid = v1;
    req0_a = a;  req0_b = b;  req0_op = op;
    req1_a = ~a; req1_b = ~b; req1_op = op;
    alu_cmd_ready = (bp == 0);
    alu_rsp_valid = 1'b0;
    #2;
    check({tag, "_ready"}, exp_g ? req1_ready : req0_ready, 1);
    check({tag, "_other_ready"}, exp_g ? req0_ready : req1_ready, 0);
    step();
    if (!hold) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
    #2;
    check({tag, "_cmd_valid"}, alu_cmd_valid, 1);
    check({tag, "_cmd_a"}, alu_cmd_a, ea);
    check({tag, "_grant"}, grant, exp_g);
    for (int i = 1; i <= bp; i++) begin
      step();
      if (i == bp) alu_cmd_ready = 1'b1;
      #2;
      check({tag, "_bp_cmd_valid"}, alu_cmd_valid, 1);
      check({tag, "_bp_cmd_b"}, alu_cmd_b, eb);
      check({tag, "_bp_busy"}, busy, 1);
      check({tag, "_bp_timeout"}, timeout, 0);
    end
    step();
    alu_cmd_ready = 1'b0;
    for (int w = 1; w <= TO; w++) begin
      if (w == dly) begin
        alu_rsp_valid = 1'b1; alu_rsp_result = res;
        alu_rsp_flags = flg;  alu_rsp_err = e;
      end
      step();
      alu_rsp_valid = 1'b0;
      if (w == dly) break;
    end
    #2;
    check({tag, "_rsp_valid"}, exp_g ? rsp1_valid : rsp0_valid, 1);
    check({tag, "_rsp_other"}, exp_g ? rsp0_valid : rsp1_valid, 0);
    check({tag, "_rsp_result"}, exp_g ? rsp1_result : rsp0_result, to ? '0 : res);
    check({tag, "_rsp_flags"}, exp_g ? rsp1_flags : rsp0_flags, to ? 4'h0 : flg);
    check({tag, "_rsp_err"}, exp_g ? rsp1_err : rsp0_err, to ? 1'b1 : e);
    check({tag, "_timeout"}, timeout, to);
    step();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_cmd_valid", alu_cmd_valid, 0);
    step();

    // Single request: 5 + 3 replied as 8 two cycles after the command.
    txn(1, 0, 0, 0, 2, 32'h5, 32'h3, 3'b100, 32'h8, 4'h0, 1'b0, 0, "single");

    // Stray ALU response while idle must be ignored.
    alu_rsp_valid = 1'b1; alu_rsp_result = 32'hdead_beef; alu_rsp_err = 1'b1;
    step();
    alu_rsp_valid = 1'b0;
    #2;
    check("stray_rsp0", rsp0_valid, 0);
    check("stray_rsp1", rsp1_valid, 0);
    check("stray_busy", busy, 0);
    step();

    // Timeout with no response.
    txn(0, 1, 0, 0, -1, $urandom, $urandom, 3'b101, 32'h1234, 4'hf, 1'b0, 1, "tmo");
    // Response in the last WAIT cycle wins over the timeout.
    txn(1, 0, 0, 0, TO, $urandom, $urandom, 3'b001, 32'hcafe_f00d, 4'h9, 1'b1, 0, "bound");
    // Long command backpressure, then a normal reply.
    txn(0, 1, 0, 50, 3, $urandom, $urandom, 3'b000, 32'h0bad_0001, 4'h2, 1'b0, 1, "bp");

    // Reset in the middle of WAIT after granting requester 0.
    req0_valid = 1'b1; alu_cmd_ready = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    alu_cmd_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    check("rstw_busy", busy, 0);
    check("rstw_cmd_valid", alu_cmd_valid, 0);
    check("rstw_rsp", {rsp0_valid, rsp1_valid, timeout}, 0);
    repeat (TO + 2) step();

    // Contention after reset: grants alternate starting with requester 0.
    for (int k = 0; k < 4; k++)
      txn(1, 1, 1, 0, 1 + k % 2, $urandom, $urandom, 3'($urandom_range(0, 7)),
          $urandom, 4'($urandom_range(0, 15)), 1'b0, (k % 2) == 1, "cont");
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Randomized traffic, including stray responses and rare resets.
    for (int i = 0; i < 4000; i++) begin
      rst            = ($urandom_range(0, 299) == 0);
      req0_valid     = ($urandom_range(0, 2) != 0);
      req1_valid     = ($urandom_range(0, 2) != 0);
      req0_a         = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7));
      req1_a         = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7));
      alu_cmd_ready  = ($urandom_range(0, 1) == 1);
      alu_rsp_valid  = ($urandom_range(0, 6) == 0);
      alu_rsp_result = $urandom;
      alu_rsp_flags  = 4'($urandom_range(0, 15));
      alu_rsp_err    = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; alu_rsp_valid = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
